// File: rtl/cp0_regfile.sv
// CP0 register file (BadVAddr/Count/Compare/Status/Cause/EPC) with prescaled timer and
// registered interrupt request; exception/ERET/MTC0 driven from WB, MFC0 read is combinational.
module cp0_regfile #(
    parameter int EXT_INT_W = 6,
    parameter int COUNT_DIV = 2,
    parameter bit RESET_BEV = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 wb_valid,
    input  logic                 wb_ex,
    input  logic                 wb_bd,
    input  logic [4:0]           wb_excode,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 eret_flush,
    input  logic                 mtc0_we,
    input  logic [7:0]           cp0_addr,
    input  logic [31:0]          mtc0_wdata,
    output logic [31:0]          cp0_rdata,
    output logic [31:0]          epc_out,
    output logic                 status_exl,
    output logic                 int_req
);

    localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;
    logic [31:0]          epc_q, epc_d;
    logic [7:0]           im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic                 ti_q, ti_d;
    logic [1:0]           ip_sw_q, ip_sw_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [EXT_INT_W-1:0] ext_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 cnt_armed_q, cnt_armed_d;
    logic                 int_req_q, int_req_d;

    logic        ex, er, wr;
    logic [5:0]  ext_pad;
    logic [7:0]  ip;
    logic [31:0] status_rd, cause_rd;

    assign ex = wb_valid & wb_ex;
    assign er = wb_valid & eret_flush & ~wb_ex;
    assign wr = wb_valid & mtc0_we & ~wb_ex;

    // Line 5 shares IP7 with the timer; narrower configurations leave the top lines at 0.
    assign ext_pad = 6'(ext_q);
    assign ip      = {ti_q | ext_pad[5], ext_pad[4:0], ip_sw_q};

    assign status_rd = {9'b0, RESET_BEV, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

    always_comb begin
        cp0_rdata = 32'b0;
        case (cp0_addr)
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_q;
            ADDR_COMPARE:  cp0_rdata = compare_q;
            ADDR_STATUS:   cp0_rdata = status_rd;
            ADDR_CAUSE:    cp0_rdata = cause_rd;
            ADDR_EPC:      cp0_rdata = epc_q;
            default:       cp0_rdata = 32'b0;
        endcase
    end

    assign epc_out    = epc_q;
    assign status_exl = exl_q;
    assign int_req    = int_req_q;

    always_comb begin
        badvaddr_d  = badvaddr_q;
        count_d     = count_q;
        compare_d   = compare_q;
        epc_d       = epc_q;
        im_d        = im_q;
        exl_d       = exl_q;
        ie_d        = ie_q;
        bd_d        = bd_q;
        ip_sw_d     = ip_sw_q;
        exccode_d   = exccode_q;
        presc_d     = presc_q;
        cnt_armed_d = cnt_armed_q;

        // A Count write restarts the prescaler and suppresses this cycle's tick.
        if (wr && cp0_addr == ADDR_COUNT) begin
            count_d = mtc0_wdata;
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            count_d     = count_q + 32'd1;
            presc_d     = '0;
            cnt_armed_d = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Match is ignored until Count has ticked once, so 0==0 out of reset is not a hit.
        ti_d = ti_q | (cnt_armed_q & (count_q == compare_q));
        if (wr && cp0_addr == ADDR_COMPARE) begin
            ti_d = 1'b0;
        end

        if (ex) begin
            if (!exl_q) begin
                epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
                bd_d  = wb_bd;
            end
            exccode_d = wb_excode;
            if (wb_excode == 5'd4 || wb_excode == 5'd5) begin
                badvaddr_d = wb_badvaddr;
            end
            exl_d = 1'b1;
        end else if (er) begin
            exl_d = 1'b0;
        end else if (wr) begin
            case (cp0_addr)
                ADDR_COMPARE: compare_d = mtc0_wdata;
                ADDR_STATUS: begin
                    im_d  = mtc0_wdata[15:8];
                    exl_d = mtc0_wdata[1];
                    ie_d  = mtc0_wdata[0];
                end
                ADDR_CAUSE: ip_sw_d = mtc0_wdata[9:8];
                ADDR_EPC:   epc_d   = mtc0_wdata;
                default: ;
            endcase
        end

        int_req_d = ie_q & ~exl_q & (|(ip & im_q)) & ~ex & ~er;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q  <= 32'b0;
            count_q     <= 32'b0;
            compare_q   <= 32'b0;
            epc_q       <= 32'b0;
            im_q        <= 8'b0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            bd_q        <= 1'b0;
            ti_q        <= 1'b0;
            ip_sw_q     <= 2'b0;
            exccode_q   <= 5'b0;
            ext_q       <= '0;
            presc_q     <= '0;
            cnt_armed_q <= 1'b0;
            int_req_q   <= 1'b0;
        end else begin
            badvaddr_q  <= badvaddr_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            epc_q       <= epc_d;
            im_q        <= im_d;
            exl_q       <= exl_d;
            ie_q        <= ie_d;
            bd_q        <= bd_d;
            ti_q        <= ti_d;
            ip_sw_q     <= ip_sw_d;
            exccode_q   <= exccode_d;
            ext_q       <= ext_int;
            presc_q     <= presc_d;
            cnt_armed_q <= cnt_armed_d;
            int_req_q   <= int_req_d;
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized and directed bench for cp0_regfile against a word-level behavioural model.
module tb_cp0_regfile;

    localparam int EXT_INT_W = 6;
    localparam int COUNT_DIV = 2;
    localparam bit RESET_BEV = 1'b1;

    localparam logic [7:0] A_BADV = 8'h40;
    localparam logic [7:0] A_CNT  = 8'h48;
    localparam logic [7:0] A_CMP  = 8'h58;
    localparam logic [7:0] A_STS  = 8'h60;
    localparam logic [7:0] A_CAU  = 8'h68;
    localparam logic [7:0] A_EPC  = 8'h70;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [EXT_INT_W-1:0] ext_int = '0;
    logic                 wb_valid = 1'b0, wb_ex = 1'b0, wb_bd = 1'b0;
    logic [4:0]           wb_excode = '0;
    logic [31:0]          wb_pc = '0, wb_badvaddr = '0;
    logic                 eret_flush = 1'b0, mtc0_we = 1'b0;
    logic [7:0]           cp0_addr = '0;
    logic [31:0]          mtc0_wdata = '0;
    logic [31:0]          cp0_rdata, epc_out;
    logic                 status_exl, int_req;

    cp0_regfile #(
        .EXT_INT_W(EXT_INT_W),
        .COUNT_DIV(COUNT_DIV),
        .RESET_BEV(RESET_BEV)
    ) dut (
        .clk(clk), .reset(reset), .ext_int(ext_int),
        .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode),
        .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
        .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
        .cp0_rdata(cp0_rdata), .epc_out(epc_out), .status_exl(status_exl), .int_req(int_req)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_badv, m_count, m_compare, m_epc, m_status;
    logic        m_bd, m_ti, m_int, m_armed;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exccode;
    logic [5:0]  m_ext;
    int          m_ticks;

    function automatic logic [7:0] m_ip();
        logic [7:0] ip;
        ip = 8'h00;
        ip[1:0] = m_ipsw;
        for (int i = 0; i < 5; i++) ip[2+i] = m_ext[i];
        ip[7] = m_ti | ((EXT_INT_W == 6) ? m_ext[5] : 1'b0);
        return ip;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_BADV:  return m_badv;
            A_CNT:   return m_count;
            A_CMP:   return m_compare;
            A_STS:   return m_status;
            A_CAU:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exccode, 2'b0};
            A_EPC:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0;
        m_status = 32'(RESET_BEV) << 22;
        m_bd = 0; m_ti = 0; m_int = 0; m_armed = 0;
        m_ipsw = 0; m_exccode = 0; m_ext = 0; m_ticks = 0;
    endtask

    task automatic m_step();
        bit ex, er, wr, match, intr;
        ex = wb_valid && wb_ex;
        er = wb_valid && eret_flush && !wb_ex;
        wr = wb_valid && mtc0_we && !wb_ex;
        intr  = m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'h00) && !ex && !er;
        match = m_armed && (m_count == m_compare);
        m_ticks++;
        if (wr && cp0_addr == A_CNT) begin
            m_count = mtc0_wdata;
            m_ticks = 0;
        end else if (m_ticks % COUNT_DIV == 0) begin
            m_count = m_count + 1;
            m_armed = 1;
        end
        if (match) m_ti = 1;
        if (wr && cp0_addr == A_CMP) m_ti = 0;
        if (ex) begin
            if (!m_status[1]) begin
                m_epc = wb_bd ? wb_pc - 4 : wb_pc;
                m_bd  = wb_bd;
            end
            m_exccode = wb_excode;
            if (wb_excode == 4 || wb_excode == 5) m_badv = wb_badvaddr;
            m_status[1] = 1;
        end else if (er) begin
            m_status[1] = 0;
        end else if (wr) begin
            case (cp0_addr)
                A_CMP: m_compare = mtc0_wdata;
                A_STS: m_status = (m_status & ~32'h0000FF03) | (mtc0_wdata & 32'h0000FF03);
                A_CAU: m_ipsw = mtc0_wdata[9:8];
                A_EPC: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
        m_ext = 6'(ext_int);
        m_int = intr;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", cp0_rdata, m_read(cp0_addr));
            chk("epc_out", epc_out, m_epc);
            chk("status_exl", 32'(status_exl), 32'(m_status[1]));
            chk("int_req", 32'(int_req), 32'(m_int));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wb_valid = 0; wb_ex = 0; eret_flush = 0; mtc0_we = 0; wb_bd = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        cp0_addr = a; mtc0_wdata = d; wb_valid = 1; mtc0_we = 1;
        step(1);
        idle();
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bva, input logic eret);
        wb_valid = 1; wb_ex = 1; wb_excode = code; wb_pc = pc; wb_bd = bd;
        wb_badvaddr = bva; eret_flush = eret;
        step(1);
        idle();
    endtask

    task automatic rd(input logic [7:0] a);
        cp0_addr = a;
        #1;
    endtask

    initial begin
        logic [7:0] addr_tab [7];
        addr_tab = '{A_BADV, A_CNT, A_CMP, A_STS, A_CAU, A_EPC, 8'h41};

        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;

        // Count==Compare==0 out of reset must not raise TI
        step(1); rd(A_CAU); chk("ti_reset_corner1", cp0_rdata, 32'h0);
        step(1); rd(A_CAU); chk("ti_reset_corner2", cp0_rdata, 32'h0);
        rd(A_STS); chk("status_reset", cp0_rdata, 32'h0040_0000);

        // Count wrap and timer match
        mtc0(A_CNT, 32'hFFFF_FFFE);
        mtc0(A_CMP, 32'h1);
        step(3); rd(A_CNT); chk("count_wrap", cp0_rdata, 32'h0);
        step(2); rd(A_CAU); chk("ti_before", 32'(cp0_rdata[30]), 32'h0);
        step(1); rd(A_CAU); chk("ti_after_wrap", 32'(cp0_rdata[30]), 32'h1);

        // Timer interrupt through IM7
        mtc0(A_CNT, 32'h100);
        mtc0(A_CMP, 32'h103);
        mtc0(A_STS, 32'h8001);
        step(4); rd(A_CAU); chk("ti_not_yet", 32'(cp0_rdata[30]), 32'h0);
        step(1); rd(A_CAU); chk("ti_match", 32'(cp0_rdata[30]), 32'h1);
        chk("int_req_lag", 32'(int_req), 32'h0);
        step(1); chk("int_req_timer", 32'(int_req), 32'h1);
        mtc0(A_CMP, 32'h0);
        rd(A_CAU); chk("ti_cleared", 32'(cp0_rdata[30]), 32'h0);
        step(1); chk("int_req_dropped", 32'(int_req), 32'h0);

        // Nested exception
        exc(5'd8, 32'hBFC0_0104, 1'b1, 32'h0, 1'b0);
        rd(A_EPC); chk("epc_bd", cp0_rdata, 32'hBFC0_0100);
        rd(A_CAU); chk("cause_bd", 32'(cp0_rdata[31]), 32'h1);
        chk("exl_set", 32'(status_exl), 32'h1);
        exc(5'd10, 32'h8000_0180, 1'b0, 32'h0, 1'b0);
        rd(A_EPC); chk("epc_nested", cp0_rdata, 32'hBFC0_0100);
        rd(A_CAU); chk("cause_nested", cp0_rdata & 32'h8000_007C, 32'h8000_0028);

        // AdEL, ex+eret, eret
        exc(5'd4, 32'h8000_0200, 1'b0, 32'h0000_0003, 1'b0);
        rd(A_BADV); chk("badvaddr", cp0_rdata, 32'h3);
        exc(5'd12, 32'h8000_0204, 1'b0, 32'h0, 1'b1);
        chk("exl_ex_eret", 32'(status_exl), 32'h1);
        wb_valid = 1; eret_flush = 1; step(1); idle();
        chk("exl_eret", 32'(status_exl), 32'h0);

        // External and software interrupts
        mtc0(A_STS, 32'h0401);
        ext_int = 6'b000001;
        step(1); rd(A_CAU); chk("ip2_sampled", 32'(cp0_rdata[10]), 32'h1);
        chk("int_req_ext_lag", 32'(int_req), 32'h0);
        step(1); chk("int_req_ext", 32'(int_req), 32'h1);
        ext_int = '0;
        mtc0(A_STS, 32'h0301);
        mtc0(A_CAU, 32'h0000_0300);
        step(1); chk("int_req_sw", 32'(int_req), 32'h1);

        // Asynchronous reset mid-count
        mtc0(A_CNT, 32'h55);
        rd(A_CNT); chk("count_pre_reset", cp0_rdata, 32'h55);
        reset = 1;
        #1;
        chk("count_async_reset", cp0_rdata, 32'h0);
        chk("int_req_async_reset", 32'(int_req), 32'h0);
        chk("epc_async_reset", epc_out, 32'h0);
        rd(A_STS); chk("status_async_reset", cp0_rdata, 32'h0040_0000);
        rd(A_CAU); chk("cause_async_reset", cp0_rdata, 32'h0);
        step(2);
        reset = 0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step(1);
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_ex      = ($urandom_range(0, 15) == 0);
            eret_flush = ($urandom_range(0, 15) == 0);
            mtc0_we    = ($urandom_range(0, 2) == 0);
            wb_bd      = 1'($urandom_range(0, 1));
            wb_excode  = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            wb_pc      = $urandom;
            wb_badvaddr = $urandom;
            cp0_addr   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_tab[$urandom_range(0, 6)];
            mtc0_wdata = $urandom;
            if (cp0_addr == A_CMP && $urandom_range(0, 1) == 0)
                mtc0_wdata = m_count + 32'($urandom_range(0, 4));
            if (cp0_addr == A_CNT && $urandom_range(0, 1) == 0)
                mtc0_wdata = m_compare - 32'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) ext_int = EXT_INT_W'($urandom);
        end
        step(1);
        idle();
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
